// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared digit codes, capture states and segment decoding for the display driver
package seg_pkg;

   localparam logic [4:0] DIG_DASH  = 5'd16;
   localparam logic [4:0] DIG_BLANK = 5'd17;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      COMMIT  = 2'd2
   } cap_state_t;

   // Active-low {g,f,e,d,c,b,a}; unknown codes fall through to dark.
   function automatic logic [6:0] seg_pattern(input logic [4:0] code);
      case (code)
         5'd0:     return 7'b1000000;
         5'd1:     return 7'b1111001;
         5'd2:     return 7'b0100100;
         5'd3:     return 7'b0110000;
         5'd4:     return 7'b0011001;
         5'd5:     return 7'b0010010;
         5'd6:     return 7'b0000010;
         5'd7:     return 7'b1111000;
         5'd8:     return 7'b0000000;
         5'd9:     return 7'b0010000;
         5'd10:    return 7'b0001000;
         5'd11:    return 7'b0000011;
         5'd12:    return 7'b1000110;
         5'd13:    return 7'b0100001;
         5'd14:    return 7'b0000110;
         5'd15:    return 7'b0001110;
         DIG_DASH: return 7'b0111111;
         default:  return 7'b1111111;
      endcase
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble converter, 14-bit binary to 4 BCD digits
module bin2bcd_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [13:0] bin,
   output logic        busy,
   output logic        done,
   output logic [15:0] bcd
);

   // [31:16] BCD accumulator, [15:0] binary being shifted out
   logic [31:0] sh_q;
   logic [3:0]  iter_q;

   function automatic logic [31:0] dd_step(input logic [31:0] x);
      logic [31:0] y;
      y = x;
      for (int i = 0; i < 4; i++) begin
         if (y[16 + 4*i +: 4] >= 4'd5)
            y[16 + 4*i +: 4] = y[16 + 4*i +: 4] + 4'd3;
      end
      return {y[30:0], 1'b0};
   endfunction

   // The first iteration happens on the start edge (adjusting an all-zero
   // accumulator is a no-op), so 16 iterations finish 15 edges later.
   always_ff @(posedge clk) begin
      if (reset) begin
         sh_q   <= '0;
         iter_q <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start && !busy) begin
            sh_q   <= dd_step({16'h0000, 2'b00, bin});
            iter_q <= 4'd1;
            busy   <= 1'b1;
         end else if (busy) begin
            sh_q   <= dd_step(sh_q);
            iter_q <= iter_q + 4'd1;
            if (iter_q == 4'd15) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign bcd = sh_q[31:16];

endmodule

// File: rtl/seven_segment_driver.sv
// rtl/seven_segment_driver.sv - captures a 16-bit value, formats hex/decimal, scans a 4-digit common-anode display
module seven_segment_driver #(
   parameter int REFRESH_DIV = 100000,
   parameter int CNT_W       = 17
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic        load,
   input  logic [15:0] value,
   input  logic        decimal_mode,
   input  logic        blank_zeros,
   output logic        busy,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an
);

   import seg_pkg::*;

   localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);

   cap_state_t  state_q, state_d;
   logic        conv_start, cap_hex, cap_dash;
   logic        conv_busy, conv_done;
   logic [15:0] conv_bcd;

   logic [4:0]  pending [4];
   logic [4:0]  shown   [4];
   logic [4:0]  disp    [4];
   logic        lead;

   logic [CNT_W-1:0] rcnt_q;
   logic [1:0]       idx_q;

   bin2bcd_seq u_bcd (
      .clk   (clk),
      .reset (reset),
      .start (conv_start),
      .bin   (value[13:0]),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      conv_start = 1'b0;
      cap_hex    = 1'b0;
      cap_dash   = 1'b0;
      case (state_q)
         IDLE: begin
            if (load && clk_enable) begin
               if (!decimal_mode) begin
                  cap_hex = 1'b1;
                  state_d = COMMIT;
               end else if (value > 16'd9999) begin
                  cap_dash = 1'b1;
                  state_d  = COMMIT;
               end else begin
                  conv_start = 1'b1;
                  state_d    = CONVERT;
               end
            end
         end
         CONVERT: begin
            // Losing the converter without a done pulse would otherwise hang here.
            if (conv_done)       state_d = COMMIT;
            else if (!conv_busy) state_d = IDLE;
         end
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Shown digits only move at COMMIT so intermediate BCD never reaches the pins.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            pending[i] <= '0;
            shown[i]   <= '0;
         end
      end else begin
         busy <= (state_d != IDLE);
         for (int i = 0; i < 4; i++) begin
            if (cap_hex)
               pending[i] <= {1'b0, value[4*i +: 4]};
            else if (cap_dash)
               pending[i] <= DIG_DASH;
            else if (state_q == CONVERT && conv_done)
               pending[i] <= {1'b0, conv_bcd[4*i +: 4]};
            if (state_q == COMMIT)
               shown[i] <= pending[i];
         end
      end
   end

   always_comb begin
      lead = 1'b1;
      for (int i = 0; i < 4; i++) disp[i] = shown[i];
      for (int i = 3; i >= 1; i--) begin
         if (blank_zeros && lead && shown[i] == 5'd0)
            disp[i] = DIG_BLANK;
         else
            lead = 1'b0;
      end
   end

   // an and seg both follow idx_q, so they always change together.
   always_ff @(posedge clk) begin
      if (reset) begin
         rcnt_q <= '0;
         idx_q  <= '0;
         an     <= 4'b1111;
         seg    <= 7'b1111111;
         dp     <= 1'b1;
      end else begin
         if (rcnt_q == REFRESH_LAST) begin
            rcnt_q <= '0;
            idx_q  <= idx_q + 2'd1;
         end else begin
            rcnt_q <= rcnt_q + CNT_W'(1);
         end
         an  <= ~(4'b0001 << idx_q);
         seg <= seg_pattern(disp[idx_q]);
         dp  <= 1'b1;
      end
   end

endmodule
